// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared constants and FIFO operation encoding for the FIR
//               decimating output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

   // Depth of the FIR tap pipeline; samples before it is full are invalid.
   localparam int FIR_LAT    = 10;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_OUT_W  = 16;
   localparam int DEF_DEPTH  = 8;
   localparam int DEF_SHIFT  = 8;
   localparam int DEF_DECIM  = 4;

   typedef enum logic [1:0] {
      FIFO_IDLE = 2'd0,
      FIFO_PUSH = 2'd1,
      FIFO_POP  = 2'd2,
      FIFO_BOTH = 2'd3
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic wr, input logic rd);
      return fifo_op_e'({rd, wr});
   endfunction

endpackage : fir_pkg

`default_nettype wire

// File: rtl/fir_sync_fifo.sv
// ============================================================================
// Module      : fir_sync_fifo
// Description : Single-clock FIFO; a push into a full FIFO succeeds only when
//               a pop happens in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_sync_fifo
   import fir_pkg::*;
#(
   parameter int WIDTH = DEF_OUT_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      level_q;
   logic             w_wr_en;
   logic             w_rd_en;

   assign empty   = (level_q == '0);
   assign full    = (level_q == (AW+1)'(DEPTH));
   assign level   = level_q;
   assign w_rd_en = pop && !empty;
   assign w_wr_en = push && (!full || w_rd_en);
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (w_wr_en) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
         end
         if (w_rd_en) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         case (fifo_op(w_wr_en, w_rd_en))
            FIFO_PUSH: level_q <= level_q + 1'b1;
            FIFO_POP:  level_q <= level_q - 1'b1;
            default:   level_q <= level_q;
         endcase
      end
   end

   // Storage carries no reset; the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

endmodule : fir_sync_fifo

`default_nettype wire

// File: rtl/fir_decim_buf.sv
// ============================================================================
// Module      : fir_decim_buf
// Description : Qualifies FIR output samples after pipeline fill, decimates,
//               narrows with saturation and buffers into an output FIFO.
//               Define FIR_DECIM_ROUND_EN for round-half-up narrowing.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_decim_buf
   import fir_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int SHIFT  = DEF_SHIFT,
   parameter int DECIM  = DEF_DECIM,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     x_vld,
   input  logic [DATA_W-1:0]        y,
   output logic                     m_vld,
   input  logic                     m_rdy,
   output logic [OUT_W-1:0]         m_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int FILL_W = $clog2(FIR_LAT + 1);
   localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int EXT_W  = (DATA_W + 1 > OUT_W) ? DATA_W + 1 : OUT_W + 1;
   localparam int RB_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

   localparam logic signed [EXT_W-1:0] SAT_MAX =
      {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] SAT_MIN =
      {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic signed [EXT_W-1:0] ROUND_BIAS =
      (SHIFT > 0) ? (EXT_W'(1) << RB_POS) : '0;

   logic              vld_d1_q;
   logic [FILL_W-1:0] fill_cnt_q;
   logic [FILL_W-1:0] fill_cnt_d;
   logic [PH_W-1:0]   ph_q;
   logic [PH_W-1:0]   ph_d;
   logic              ovf_q;
   logic              ovf_d;

   logic              w_qual;
   logic              w_push;
   logic              w_full;
   logic              w_empty;
   logic              w_overflow;
   logic [OUT_W-1:0]  w_narrow;

   logic signed [EXT_W-1:0] w_y_ext;
   logic signed [EXT_W-1:0] w_sum;
   logic signed [EXT_W-1:0] w_shifted;

   // Fill counter and decimation phase both restart on any gap in vld_d1.
   always_comb begin
      fill_cnt_d = '0;
      ph_d       = '0;
      w_qual     = vld_d1_q && (fill_cnt_q == FILL_W'(FIR_LAT));
      if (vld_d1_q) begin
         fill_cnt_d = (fill_cnt_q == FILL_W'(FIR_LAT)) ? fill_cnt_q
                                                        : fill_cnt_q + 1'b1;
         ph_d       = ph_q;
         if (w_qual) begin
            ph_d = (ph_q == PH_W'(DECIM - 1)) ? '0 : ph_q + 1'b1;
         end
      end
   end

   assign w_push = w_qual && (ph_q == '0);

   always_comb begin
      w_y_ext = {{(EXT_W-DATA_W){y[DATA_W-1]}}, y};
`ifdef FIR_DECIM_ROUND_EN
      w_sum   = w_y_ext + ROUND_BIAS;
`else
      w_sum   = w_y_ext;
`endif
      w_shifted = w_sum >>> SHIFT;
      if (w_shifted > SAT_MAX) begin
         w_narrow = SAT_MAX[OUT_W-1:0];
      end else if (w_shifted < SAT_MIN) begin
         w_narrow = SAT_MIN[OUT_W-1:0];
      end else begin
         w_narrow = w_shifted[OUT_W-1:0];
      end
   end

   // A push into a full FIFO is lost unless a pop frees the slot this cycle.
   assign m_vld      = !w_empty;
   assign w_overflow = w_push && w_full && !(m_vld && m_rdy);
   assign ovf_d      = w_overflow ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   assign ovf        = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_d1_q   <= 1'b0;
         fill_cnt_q <= '0;
         ph_q       <= '0;
         ovf_q      <= 1'b0;
      end else begin
         vld_d1_q   <= x_vld;
         fill_cnt_q <= fill_cnt_d;
         ph_q       <= ph_d;
         ovf_q      <= ovf_d;
      end
   end

   fir_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .wdata (w_narrow),
      .pop   (m_rdy),
      .rdata (m_data),
      .full  (w_full),
      .empty (w_empty),
      .level (level)
   );

endmodule : fir_decim_buf

`default_nettype wire

// File: tb/tb_fir_decim_buf.sv
// ============================================================================
// Module      : tb_fir_decim_buf
// Description : Scoreboard bench for fir_decim_buf with two configurations
//               (DECIM=1/SHIFT=0 and DECIM=4/SHIFT=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_decim_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst_n, a_x_vld, a_m_vld, a_m_rdy, a_ovf, a_ovf_clr;
   logic [31:0] a_y;
   logic [15:0] a_m_data;
   logic [3:0]  a_level;

   logic        b_rst_n, b_x_vld, b_m_vld, b_m_rdy, b_ovf, b_ovf_clr;
   logic [31:0] b_y;
   logic [15:0] b_m_data;
   logic [3:0]  b_level;

   int n_checks = 0;
   int n_err    = 0;

   logic [15:0] a_q[$];
   logic [15:0] b_q[$];

   fir_decim_buf #(
      .DATA_W(32), .OUT_W(16), .SHIFT(0), .DECIM(1), .DEPTH(8)
   ) dut_a (
      .clk(clk), .rst_n(a_rst_n), .x_vld(a_x_vld), .y(a_y),
      .m_vld(a_m_vld), .m_rdy(a_m_rdy), .m_data(a_m_data),
      .level(a_level), .ovf(a_ovf), .ovf_clr(a_ovf_clr)
   );

   fir_decim_buf #(
      .DATA_W(32), .OUT_W(16), .SHIFT(8), .DECIM(4), .DEPTH(8)
   ) dut_b (
      .clk(clk), .rst_n(b_rst_n), .x_vld(b_x_vld), .y(b_y),
      .m_vld(b_m_vld), .m_rdy(b_m_rdy), .m_data(b_m_data),
      .level(b_level), .ovf(b_ovf), .ovf_clr(b_ovf_clr)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output monitors: every accepted beat must match the scoreboard head.
   always @(negedge clk) begin
      if (a_rst_n && a_m_vld && a_m_rdy) begin
         if (a_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL a_extra_output: got %0h with nothing expected", a_m_data);
         end else begin
            chk("a_data", {16'h0, a_m_data}, {16'h0, a_q.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (b_rst_n && b_m_vld && b_m_rdy) begin
         if (b_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL b_extra_output: got %0h with nothing expected", b_m_data);
         end else begin
            chk("b_data", {16'h0, b_m_data}, {16'h0, b_q.pop_front()});
         end
      end
   end

   initial begin
      a_rst_n = 1'b0; a_x_vld = 1'b0; a_y = '0; a_m_rdy = 1'b1; a_ovf_clr = 1'b0;
      b_rst_n = 1'b0; b_x_vld = 1'b0; b_y = '0; b_m_rdy = 1'b1; b_ovf_clr = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_a_mvld",  {31'h0, a_m_vld}, 32'h0);
      chk("rst_a_level", {28'h0, a_level}, 32'h0);
      chk("rst_a_ovf",   {31'h0, a_ovf},   32'h0);
      chk("rst_a_mdata", {16'h0, a_m_data}, 32'h0);
      chk("rst_b_mvld",  {31'h0, b_m_vld}, 32'h0);
      chk("rst_b_level", {28'h0, b_level}, 32'h0);
      chk("rst_b_ovf",   {31'h0, b_ovf},   32'h0);
      chk("rst_b_mdata", {16'h0, b_m_data}, 32'h0);
      step();
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      repeat (2) step();

      // Test 1: fill latency, DECIM=1, y=100 constant
      for (int k = 0; k <= 22; k++) begin
         a_x_vld = (k < 20);
         a_y     = 32'd100;
         if (k >= 11 && k <= 20) a_q.push_back(16'd100);
         @(negedge clk);
         if (k == 11) begin
            chk("t1_level_c11", {28'h0, a_level}, 32'd0);
            chk("t1_mvld_c11",  {31'h0, a_m_vld}, 32'd0);
         end
         if (k == 12) begin
            chk("t1_mvld_c12",  {31'h0, a_m_vld}, 32'd1);
            chk("t1_level_c12", {28'h0, a_level}, 32'd1);
         end
         if (k == 20) chk("t1_level_c20", {28'h0, a_level}, 32'd1);
         step();
      end
      repeat (3) step();

      // Test 5: fill to DEPTH, overflow, push with pop while full, drain
      for (int k = 0; k <= 30; k++) begin
         a_x_vld = (k < 20);
         a_y     = 32'(k);
         a_m_rdy = (k >= 20);
         if (k >= 11 && k <= 20 && k != 19) a_q.push_back(16'(k));
         @(negedge clk);
         if (k == 19) begin
            chk("t5_level_full", {28'h0, a_level}, 32'd8);
            chk("t5_ovf_before", {31'h0, a_ovf},   32'd0);
         end
         if (k == 20) begin
            chk("t5_level_drop", {28'h0, a_level}, 32'd8);
            chk("t5_ovf_set",    {31'h0, a_ovf},   32'd1);
         end
         if (k == 21) chk("t5_level_pushpop", {28'h0, a_level}, 32'd8);
         if (k == 30) begin
            chk("t5_level_drained", {28'h0, a_level}, 32'd0);
            chk("t5_ovf_sticky",    {31'h0, a_ovf},   32'd1);
         end
         step();
      end
      a_ovf_clr = 1'b1;
      step();
      a_ovf_clr = 1'b0;
      @(negedge clk);
      chk("t5_ovf_clr", {31'h0, a_ovf}, 32'd0);
      step();

      // Test 6: reset with level=5, then full refill before next push
      a_m_rdy = 1'b0;
      for (int k = 0; k <= 16; k++) begin
         a_x_vld = (k < 15);
         a_y     = 32'(k);
         if (k >= 11 && k <= 15) a_q.push_back(16'(k));
         @(negedge clk);
         if (k == 16) chk("t6_level_pre", {28'h0, a_level}, 32'd5);
         step();
      end
      a_rst_n = 1'b0;
      #1;
      chk("t6_rst_mvld",  {31'h0, a_m_vld}, 32'd0);
      chk("t6_rst_level", {28'h0, a_level}, 32'd0);
      a_q.delete();
      step();
      a_rst_n = 1'b1;
      a_m_rdy = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         a_x_vld = (k < 14);
         a_y     = 32'(200 + k);
         if (k >= 11 && k <= 14) a_q.push_back(16'(200 + k));
         @(negedge clk);
         if (k == 11) chk("t6_mvld_c11", {31'h0, a_m_vld}, 32'd0);
         if (k == 12) chk("t6_mvld_c12", {31'h0, a_m_vld}, 32'd1);
         step();
      end
      repeat (3) step();

      // Test 2: DECIM=4, 40 qualified samples, pushes at indices 0,4,..,36
      for (int k = 0; k <= 52; k++) begin
         b_x_vld = (k < 50);
         b_y     = 32'(k) << 8;
         if (k >= 11 && k <= 47 && ((k - 11) % 4) == 0) b_q.push_back(16'(k));
         @(negedge clk);
         step();
      end
      repeat (3) step();

      // Test 3: saturation and narrowing at qualified indices 0,4,8,12
      for (int k = 0; k <= 26; k++) begin
         b_x_vld = (k < 24);
         case (k)
            11:      b_y = 32'h7FFF_FFFF;
            15:      b_y = 32'h8000_0000;
            19:      b_y = 32'h0000_1280;
            23:      b_y = 32'hFFFF_FE80;
            default: b_y = 32'h0;
         endcase
         if (k == 11) b_q.push_back(16'h7FFF);
         if (k == 15) b_q.push_back(16'h8000);
`ifdef FIR_DECIM_ROUND_EN
         if (k == 19) b_q.push_back(16'h0013);
         if (k == 23) b_q.push_back(16'hFFFF);
`else
         if (k == 19) b_q.push_back(16'h0012);
         if (k == 23) b_q.push_back(16'hFFFE);
`endif
         @(negedge clk);
         step();
      end
      repeat (3) step();

      // Test 4: one-cycle gap restarts fill and phase
      for (int k = 0; k <= 32; k++) begin
         b_x_vld = (k < 30) && (k != 15);
         b_y     = 32'(k) << 8;
         if (k == 11 || k == 15 || k == 27) b_q.push_back(16'(k));
         @(negedge clk);
         step();
      end
      repeat (5) step();

      @(negedge clk);
      chk("end_a_queue_empty", 32'(a_q.size()), 32'd0);
      chk("end_b_queue_empty", 32'(b_q.size()), 32'd0);
      chk("end_b_ovf",         {31'h0, b_ovf},  32'd0);
      chk("end_b_level",       {28'h0, b_level}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_fir_decim_buf

`default_nettype wire

// File: doc/fir_decim_buf.md
FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

Interface
REQ-001 Parameter DATA_W, default 32: width of the fir y sample.
REQ-002 Parameter OUT_W, default 16: width of the output sample.
REQ-003 Parameter SHIFT, default 8: arithmetic right-shift applied to y before narrowing; legal range 0..DATA_W-1.
REQ-004 Parameter DECIM, default 4: decimation factor; legal range 1..16.
REQ-005 Parameter DEPTH, default 8: output FIFO depth; power of two, minimum 2.
REQ-006 Port clk, input, 1: single clock, shared with the fir stage; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 Port x_vld, input, 1: high in the same cycle that a valid sample is driven on the fir x input.
REQ-009 Port y, input, DATA_W: the fir registered output, two's-complement.
REQ-010 Port m_vld, output, 1: output FIFO is non-empty.
REQ-011 Port m_rdy, input, 1: downstream accepts m_data.
REQ-012 Port m_data, output, OUT_W: head of the output FIFO.
REQ-013 Port level, output, $clog2(DEPTH)+1: current FIFO occupancy.
REQ-014 Port ovf, output, 1: sticky overflow flag.
REQ-015 Port ovf_clr, input, 1: clears ovf.

Function
REQ-016 x_vld shall be registered once into vld_d1, matching the one-cycle register inside the fir.
REQ-017 fill_cnt (0..FIR_LAT) shall increment when vld_d1=1, saturate at FIR_LAT, and clear to 0 in any cycle where vld_d1=0.
REQ-018 Qualified sample: vld_d1=1 and fill_cnt=FIR_LAT (value before update). Earlier samples contain partially filled taps and shall be discarded.
REQ-019 Phase counter ph (0..DECIM-1) shall advance by one per qualified sample, wrapping to 0 after DECIM-1. It shall clear to 0 whenever fill_cnt clears.
REQ-020 A qualified sample with ph=0 shall generate a push; all other qualified samples are discarded.
REQ-021 Narrowing: y is arithmetically shifted right by SHIFT, then saturated to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-022 The push shall write into the FIFO on the same edge that the sample is qualified (y to FIFO latency: 1 edge).
REQ-023 Pop occurs when m_vld and m_rdy are both high; m_data shall then advance to the next entry on the following edge.
REQ-024 If the FIFO is full and a pop occurs in the same cycle as a push, the push shall succeed and level shall remain DEPTH.
REQ-025 If the FIFO is full with no pop, the push shall be dropped and ovf set to 1; FIFO contents shall be unchanged.
REQ-026 ovf_clr shall clear ovf. If ovf_clr and a new overflow occur in the same cycle, ovf shall be 1.
REQ-027 level shall increment on push-only, decrement on pop-only, and remain unchanged on both or neither; pointers wrap modulo DEPTH.

Reset
REQ-028 While rst_n=0: vld_d1, fill_cnt, ph, level, ovf, and the read/write pointers shall be 0; m_vld=0; m_data=0.
REQ-029 Reset asserted mid-stream shall discard all FIFO contents. After release, a full FIR_LAT refill is required before the next push.

Configuration
REQ-030 With FIR_DECIM_ROUND_EN defined, 2^(SHIFT-1) shall be added to y (in DATA_W+1 bits) before the shift when SHIFT>0, giving round-half-up.
REQ-031 Without FIR_DECIM_ROUND_EN, the shift shall truncate toward negative infinity.

Structure
REQ-032 Package fir_pkg shall hold FIR_LAT=10 (fir tap-pipeline depth) and the default DATA_W, OUT_W, and DEPTH constants.
REQ-033 The FIFO shall be a sub-module, fir_sync_fifo (parameters WIDTH and DEPTH, ports clk and rst_n, push/pop interface, full/empty flags, level output).
REQ-034 Saturation and rounding logic shall be combinational inside fir_decim_buf.

Verification
REQ-035 Test 1 (fill): DECIM=1, SHIFT=0, x_vld high from cycle 0, y=100 constant. The first push shall occur at cycle 11, m_data=100, and one push shall follow per cycle thereafter.
REQ-036 Test 2 (decimation): DECIM=4, 40 qualified samples. Exactly 10 pushes, taken at qualified indices 0, 4, 8, ..., 36.
REQ-037 Test 3 (saturation): SHIFT=8. y=0x7FFFFFFF gives m_data=0x7FFF; y=0x80000000 gives 0x8000; y=0x00001280 gives 0x0012 without the macro and 0x0013 with FIR_DECIM_ROUND_EN.
REQ-038 Test 4 (gap): x_vld low for 1 cycle mid-stream. No push shall occur for the next 10 vld_d1 cycles, and ph shall restart at 0.
REQ-039 Test 5 (full): m_rdy=0 until level=8, then one further push. ovf=1 and level=8. Then m_rdy=1 with a simultaneous push: level stays 8. Pulse ovf_clr: ovf=0.
REQ-040 Test 6 (reset): rst_n pulsed low with level=5. m_vld=0 and level=0 immediately, and the next push occurs 11 cycles after vld resumes.
